dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Responder side of the pipeline data-memory interface. The MEM stage issues read/write requests;
//  this block accepts one request at a time via valid/ready, models a fixed-latency word SRAM, and
//  returns read data or a write acknowledgement. It drives a stall so the pipeline holds the MEM stage.
// PARAMETERS
//  ADDR_LEN    32   byte-address width of req_addr
//  WORD_LEN    32   data word width
//  DEPTH       256  number of words (power of 2, >=4); index = req_addr[log2(DEPTH)+1:2]
//  LATENCY     2    cycles from accept to response (>=1)
// PORTS
//  clk         in   1          rising-edge clock
//  rst         in   1          asynchronous, active-high reset
//  req_valid   in   1          MEM stage presents a request; held until resp_valid
//  req_write   in   1          1 = store, 0 = load
//  req_addr    in   ADDR_LEN   byte address
//  req_wdata   in   WORD_LEN   store data
//  req_ready   out  1          responder can accept (IDLE only)
//  resp_valid  out  1          one-cycle response pulse
//  resp_rdata  out  WORD_LEN   load data (0 for stores and errors); valid only with resp_valid
//  resp_err    out  1          misaligned/out-of-range; valid only with resp_valid
//  stall       out  1          hold IF..MEM stages this cycle
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, counter=0, latched request cleared; req_ready=1,
//    resp_valid=0, resp_rdata=0, resp_err=0. Pending access aborted; an in-flight store is NOT written.
//    Array contents are unaffected by rst (zero at time 0 in simulation).
//  - FSM: IDLE -> (accept) -> WAIT -> RESP -> IDLE. Accept = req_valid & req_ready at a clk edge;
//    addr/wdata/write latched at that edge, counter loaded with LATENCY-1.
//  - WAIT: counter decrements each edge; at counter==0 go to RESP. LATENCY=1 skips WAIT (IDLE->RESP).
//  - Access performed on the edge entering RESP: load reads array into resp_rdata; store writes array.
//  - RESP: resp_valid=1 for exactly one cycle, req_ready=0 (same request still on req_valid, not re-accepted);
//    next edge -> IDLE unconditionally. Accepted request: resp_valid high in the cycle LATENCY cycles after acceptance.
//  - Max throughput: one request per LATENCY+1 cycles; a new request is accepted the cycle after RESP.
//  - stall = (IDLE & req_valid) | WAIT. stall=0 in RESP so the pipeline advances with resp_rdata.
//  - Error: addr[1:0]!=0 or any bit above index field nonzero -> no array read/write, resp_rdata=0,
//    resp_err=1 with resp_valid; timing identical to a normal access.
//  - resp_rdata/resp_err hold their value until the next RESP or reset; consumers qualify with resp_valid.
//  - req_* changes while not in IDLE are ignored (latched copy used).
// TESTING
//  1 Reset: assert rst mid-cycle with clk idle -> req_ready=1, resp_valid=0, stall=0 immediately.
//  2 LATENCY=2: store 0xDEADBEEF @0x10, then load @0x10 -> store resp_valid 2 cycles after accept with
//    rdata=0, load resp_rdata=0xDEADBEEF, stall high for 2 cycles per request.
//  3 Back-to-back: req_valid held for 3 loads (@0x0,0x4,0x8 preloaded 1,2,3) -> accepts every 3 cycles,
//    responses 1,2,3 in order, no duplicate accept during RESP.
//  4 Errors: load @0x6 and store 0x55 @0x400 (DEPTH=256) -> resp_err=1, rdata=0; later load @0x0 unchanged.
//  5 Reset mid-WAIT of store 0x12345678 @0x20 -> no resp_valid; later load @0x20 returns prior value.
//  6 LATENCY=1 build: load @0x4 -> resp_valid the cycle after accept, stall high exactly 1 cycle.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency word SRAM responder for the pipeline MEM stage.
// Accepts one request at a time over valid/ready. The access happens on the
// edge that enters RESP. A one-cycle response pulse is returned, and a stall
// holds the pipeline while a request is pending.
module dmem_responder #(
    parameter int ADDR_LEN = 32,
    parameter int WORD_LEN = 32,
    parameter int DEPTH    = 256,
    parameter int LATENCY  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [ADDR_LEN-1:0] req_addr,
    input  logic [WORD_LEN-1:0] req_wdata,
    output logic                req_ready,
    output logic                resp_valid,
    output logic [WORD_LEN-1:0] resp_rdata,
    output logic                resp_err,
    output logic                stall
);

    localparam int IDX_W = $clog2(DEPTH);
    // The counter only ever holds LATENCY-1 down to 0.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic                write;
        logic [ADDR_LEN-1:0] addr;
        logic [WORD_LEN-1:0] wdata;
    } req_t;

    state_t              state;
    req_t                req_q;
    req_t                acc;
    logic [CNT_W-1:0]    cnt;
    logic [WORD_LEN-1:0] mem [DEPTH];

    logic             accept;
    logic             go_resp;
    logic [IDX_W-1:0] acc_idx;
    logic             acc_err;
    logic             mem_we;

    assign accept = req_valid & req_ready;

    // The access fires on the edge that moves the FSM into RESP. With
    // LATENCY=1 that edge is the accept edge itself. In WAIT, the counter
    // reaches 0 on that same edge.
    assign go_resp = (LATENCY == 1) ? (state == IDLE && accept)
                                    : (state == WAIT && cnt == CNT_W'(1));

    // Choose the request that is being serviced. With LATENCY=1 the request
    // has not been latched yet at the access edge, so the live inputs are used.
    always_comb begin
        acc = req_q;
        if (LATENCY == 1) begin
            acc.write = req_write;
            acc.addr  = req_addr;
            acc.wdata = req_wdata;
        end
    end

    // Word index and error decode: the address must be word-aligned, and
    // every bit above the index field must be zero.
    assign acc_idx = acc.addr[IDX_W+1:2];
    assign acc_err = (acc.addr[1:0] != 2'b00) ||
                     ((acc.addr >> (IDX_W + 2)) != '0);

    // Erroneous stores never reach the array. Reset blocks a write that is
    // landing on the same edge.
    assign mem_we = go_resp & acc.write & ~acc_err & ~rst;

    // Hold the pipeline while a request waits to be accepted or is in flight.
    // RESP releases the pipeline so it consumes resp_rdata.
    assign stall = (state == IDLE && req_valid) || (state == WAIT);

    // Storage array; its contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[acc_idx] <= acc.wdata;
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            // Response data holds between responses; loads return array
            // data, while stores and errors return zero.
            if (go_resp) begin
                resp_rdata <= (acc.write || acc_err) ? '0 : mem[acc_idx];
                resp_err   <= acc_err;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_q.write <= req_write;
                        req_q.addr  <= req_addr;
                        req_q.wdata <= req_wdata;
                        cnt         <= CNT_W'(LATENCY - 1);
                        req_ready   <= 1'b0;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    // Unconditional return to IDLE. The request that is still
                    // held is not re-accepted, because ready was low this cycle.
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
